// File: rtl/aim_pkg.sv
// rtl/aim_pkg.sv - shared AIM geometry constants and decoder state type
package aim_pkg;

    localparam int AIM_N_WORDS = 32;
    localparam int AIM_MAP_W   = 32;
    localparam int AIM_POS_W   = 9;
    localparam int AIM_ITE_W   = AIM_POS_W - $clog2(AIM_MAP_W);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_EMIT = 1'b1
    } aim_dec_state_e;

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - binary index to one-hot row, inverse of the AIM row encoder
module onehot_decoder #(
    parameter int W = 32
) (
    input  logic                 i_en,
    input  logic [$clog2(W)-1:0] i_idx,
    output logic [W-1:0]         o_onehot
);

    assign o_onehot = i_en ? (W'(1) << i_idx) : '0;

endmodule

// File: rtl/aim_decoder.sv
// rtl/aim_decoder.sv - buffers a batch of match results and replays per-iteration one-hot maps
module aim_decoder
    import aim_pkg::*;
#(
    parameter int N_WORDS = AIM_N_WORDS,
    parameter int MAP_W   = AIM_MAP_W,
    parameter int POS_W   = AIM_POS_W,
    parameter int ITE_W   = POS_W - $clog2(MAP_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_hit,
    input  logic [POS_W-1:0] i_pos,
    input  logic             i_last,
    input  logic [ITE_W-1:0] i_ite,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [MAP_W-1:0] o_map [N_WORDS],
    output logic [ITE_W-1:0] o_ite,
    output logic             o_last,
    output logic             o_drop
);

    localparam int IDX_W  = $clog2(MAP_W);
    localparam int WCNT_W = $clog2(N_WORDS) + 1;

    aim_dec_state_e    state;
    logic [WCNT_W-1:0] wcnt;
    logic              hit [N_WORDS];
    logic [POS_W-1:0]  pos [N_WORDS];
    logic [ITE_W-1:0]  ite_max;
    logic [ITE_W-1:0]  ite_cnt;

    logic              accept;
    logic              close;
    logic              emit_hs;
    logic              drop_hit;
    logic [ITE_W-1:0]  ite_max_nx;
    logic [ITE_W-1:0]  in_ite;
    logic [ITE_W-1:0]  ite_sel;
    logic              hit_nx [N_WORDS];
    logic [POS_W-1:0]  pos_nx [N_WORDS];
    logic [MAP_W-1:0]  dec_map [N_WORDS];

    assign o_ready    = (state == S_LOAD) && !i_rst;
    assign o_valid    = (state == S_EMIT);
    assign o_last     = o_valid && (ite_cnt == ite_max);
    assign o_ite      = ite_cnt;

    assign accept     = i_valid && o_ready;
    assign emit_hs    = o_valid && i_ready;
    assign ite_max_nx = (wcnt == '0) ? i_ite : ite_max;
    assign in_ite     = i_pos[POS_W-1 -: ITE_W];
    assign drop_hit   = accept && i_hit && (in_ite > ite_max_nx);
    assign close      = accept && ((wcnt == WCNT_W'(N_WORDS - 1)) || i_last);
    // Map register is loaded one step ahead: iteration 0 on close, ite_cnt+1 on advance
    assign ite_sel    = (state == S_EMIT) ? ite_cnt + ITE_W'(1) : '0;

    // Buffer contents including the entry being accepted this cycle
    always_comb begin
        for (int w = 0; w < N_WORDS; w++) begin
            hit_nx[w] = hit[w];
            pos_nx[w] = pos[w];
            if (accept && (wcnt == WCNT_W'(w))) begin
                hit_nx[w] = i_hit && !drop_hit;
                pos_nx[w] = i_pos;
            end
        end
    end

    for (genvar w = 0; w < N_WORDS; w++) begin : g_row
        onehot_decoder #(.W(MAP_W)) u_dec (
            .i_en     (hit_nx[w] && (pos_nx[w][POS_W-1 -: ITE_W] == ite_sel)),
            .i_idx    (pos_nx[w][IDX_W-1:0]),
            .o_onehot (dec_map[w])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_LOAD;
            wcnt    <= '0;
            ite_max <= '0;
            ite_cnt <= '0;
            o_drop  <= 1'b0;
            for (int w = 0; w < N_WORDS; w++) begin
                hit[w]   <= 1'b0;
                pos[w]   <= '0;
                o_map[w] <= '0;
            end
        end else begin
            o_drop <= drop_hit;
            for (int w = 0; w < N_WORDS; w++) begin
                hit[w] <= hit_nx[w];
                pos[w] <= pos_nx[w];
            end
            if (accept) begin
                wcnt    <= wcnt + WCNT_W'(1);
                ite_max <= ite_max_nx;
            end
            if (close) begin
                state   <= S_EMIT;
                ite_cnt <= '0;
                for (int w = 0; w < N_WORDS; w++) o_map[w] <= dec_map[w];
            end
            if (emit_hs) begin
                if (!o_last) begin
                    ite_cnt <= ite_cnt + ITE_W'(1);
                    for (int w = 0; w < N_WORDS; w++) o_map[w] <= dec_map[w];
                end else begin
                    state   <= S_LOAD;
                    wcnt    <= '0;
                    ite_cnt <= '0;
                    for (int w = 0; w < N_WORDS; w++) begin
                        hit[w]   <= 1'b0;
                        o_map[w] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aim_decoder.sv
// tb/tb_aim_decoder.sv - directed self-checking bench for aim_decoder
module tb_aim_decoder;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_hit = 1'b0;
    logic [8:0]  i_pos = '0;
    logic        i_last = 1'b0;
    logic [3:0]  i_ite = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_map [32];
    logic [3:0]  o_ite;
    logic        o_last;
    logic        o_drop;

    logic [31:0] exp_map [32];
    int          checks = 0;
    int          errors = 0;

    always #5 i_clk = ~i_clk;

    aim_decoder dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_hit   (i_hit),
        .i_pos   (i_pos),
        .i_last  (i_last),
        .i_ite   (i_ite),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_map   (o_map),
        .o_ite   (o_ite),
        .o_last  (o_last),
        .o_drop  (o_drop)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int w = 0; w < 32; w++) exp_map[w] = '0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic push(input logic h, input logic [8:0] p, input logic l, input logic [3:0] it);
        int n = 0;
        i_valid = 1'b1; i_hit = h; i_pos = p; i_last = l; i_ite = it;
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) check("push_timeout", 1, 0);
        @(negedge i_clk);
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic expect_map(input string tag, input logic [3:0] it, input logic last);
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_ite"}, o_ite, it);
        check({tag, "_last"}, o_last, last);
        for (int w = 0; w < 32; w++)
            check($sformatf("%s_row%0d", tag, w), o_map[w], exp_map[w]);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_ready"}, o_ready, 1);
    endtask

    initial begin
        logic [31:0] any_row;

        // Reset
        repeat (3) @(negedge i_clk);
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        expect_idle("post_rst");
        check("post_rst_ite", o_ite, 0);
        check("post_rst_last", o_last, 0);
        check("post_rst_drop", o_drop, 0);
        any_row = '0;
        for (int w = 0; w < 32; w++) any_row |= o_map[w];
        check("post_rst_map", any_row, 0);

        // Full batch, pos=w
        for (int w = 0; w < 31; w++) push(1'b1, 9'(w), 1'b0, 4'd0);
        check("full_not_early", o_valid, 0);
        push(1'b1, 9'd31, 1'b0, 4'd0);
        for (int w = 0; w < 32; w++) exp_map[w] = 32'h1 << w;
        check("full_ready_low", o_ready, 0);
        expect_map("full", 4'd0, 1'b1);
        i_ready = 1'b1;
        @(negedge i_clk);
        expect_idle("full_done");

        // Three iterations, i_last on word2
        push(1'b1, 9'd5, 1'b0, 4'd2);
        push(1'b1, 9'd37, 1'b0, 4'd0);
        push(1'b1, 9'd95, 1'b1, 4'd0);
        clear_exp(); exp_map[0] = 32'h20;
        expect_map("three_i0", 4'd0, 1'b0);
        @(negedge i_clk);
        clear_exp(); exp_map[1] = 32'h20;
        expect_map("three_i1", 4'd1, 1'b0);
        @(negedge i_clk);
        clear_exp(); exp_map[2] = 32'h8000_0000;
        expect_map("three_i2", 4'd2, 1'b1);
        @(negedge i_clk);
        expect_idle("three_done");

        // Backpressure on iteration 1
        push(1'b1, 9'd5, 1'b0, 4'd2);
        push(1'b1, 9'd37, 1'b0, 4'd0);
        push(1'b1, 9'd95, 1'b1, 4'd0);
        @(negedge i_clk);
        i_ready = 1'b0;
        clear_exp(); exp_map[1] = 32'h20;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            expect_map($sformatf("stall%0d", c), 4'd1, 1'b0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        clear_exp(); exp_map[2] = 32'h8000_0000;
        expect_map("stall_i2", 4'd2, 1'b1);
        @(negedge i_clk);
        expect_idle("stall_done");

        // Out-of-range hit dropped
        push(1'b1, 9'd3, 1'b0, 4'd0);
        check("drop_none", o_drop, 0);
        push(1'b1, 9'd40, 1'b0, 4'd0);
        check("drop_pulse", o_drop, 1);
        push(1'b1, 9'd7, 1'b1, 4'd0);
        check("drop_once", o_drop, 0);
        clear_exp(); exp_map[0] = 32'h8; exp_map[2] = 32'h80;
        expect_map("drop", 4'd0, 1'b1);
        @(negedge i_clk);
        expect_idle("drop_done");

        // Reset mid-emit, then a clean batch
        push(1'b1, 9'd5, 1'b0, 4'd2);
        push(1'b1, 9'd37, 1'b0, 4'd0);
        push(1'b1, 9'd95, 1'b1, 4'd0);
        @(negedge i_clk);
        check("abort_at_i1", o_ite, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("abort_valid", o_valid, 0);
        check("abort_ready_in_rst", o_ready, 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        expect_idle("abort_idle");
        check("abort_last", o_last, 0);
        push(1'b1, 9'd73, 1'b1, 4'd2);
        clear_exp();
        expect_map("clean_i0", 4'd0, 1'b0);
        @(negedge i_clk);
        expect_map("clean_i1", 4'd1, 1'b0);
        @(negedge i_clk);
        exp_map[0] = 32'h200;
        expect_map("clean_i2", 4'd2, 1'b1);
        @(negedge i_clk);
        expect_idle("clean_done");

        // i_valid held through emit
        push(1'b1, 9'd5, 1'b0, 4'd2);
        push(1'b1, 9'd37, 1'b0, 4'd0);
        push(1'b1, 9'd95, 1'b1, 4'd0);
        i_valid = 1'b1; i_hit = 1'b1; i_pos = 9'd1; i_last = 1'b1; i_ite = 4'd0;
        check("hold_ready_i0", o_ready, 0);
        @(negedge i_clk);
        check("hold_ready_i1", o_ready, 0);
        check("hold_ite_i1", o_ite, 1);
        @(negedge i_clk);
        check("hold_ready_i2", o_ready, 0);
        check("hold_last_i2", o_last, 1);
        @(negedge i_clk);
        expect_idle("hold_reopen");
        @(negedge i_clk);
        i_valid = 1'b0; i_last = 1'b0;
        clear_exp(); exp_map[0] = 32'h2;
        expect_map("hold_next", 4'd0, 1'b1);
        @(negedge i_clk);
        expect_idle("hold_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
